and_unit_arb: RTL and testbench

AND_UNIT_ARB -- requirements
Module: and_unit_arb

---
 rtl/and_arb_pkg.sv | 27 ++
 rtl/and_reg_stage.sv | 32 +++
 rtl/and_unit_arb.sv | 124 ++++++++++++
 tb/tb_and_unit_arb.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/and_arb_pkg.sv
// Shared types and constants for the two-requester AND arbiter.
// Holds the result-stage state encoding, default width and requester ids.
package and_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int   DEFAULT_WIDTH = 8;
  localparam logic REQ0_ID       = 1'b0;
  localparam logic REQ1_ID       = 1'b1;

  // Round-robin pick: a lone requester always wins; on a tie the one not granted last wins.
  // Returns {grant1, grant0}.
  function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic last_id);
    logic [1:0] g;
    g = 2'b00;
    if (v0 && v1) begin
      g = (last_id == REQ1_ID) ? 2'b01 : 2'b10;
    end else begin
      g = {v1, v0};
    end
    return g;
  endfunction

endpackage

// File: rtl/and_reg_stage.sv
// Registered result stage: captures a & b and the issuing requester id on load.
// Contents are held while load is low.
module and_reg_stage
  import and_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             id_in,
  output logic [WIDTH-1:0] data,
  output logic             id
);

  // Result data/id register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      id   <= REQ0_ID;
    end else if (load) begin
      data <= a & b;
      id   <= id_in;
    end else begin
      data <= data;
      id   <= id;
    end
  end

endmodule

// File: rtl/and_unit_arb.sv
// Two-requester round-robin arbiter feeding a one-deep registered AND result stage,
// with per-requester completed-result counters.
module and_unit_arb
  import and_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pi_req0_valid,
  input  logic [WIDTH-1:0] pi_req0_a,
  input  logic [WIDTH-1:0] pi_req0_b,
  output logic             po_req0_ready,
  input  logic             pi_req1_valid,
  input  logic [WIDTH-1:0] pi_req1_a,
  input  logic [WIDTH-1:0] pi_req1_b,
  output logic             po_req1_ready,
  output logic             po_res_valid,
  output logic [WIDTH-1:0] po_res_data,
  output logic             po_res_id,
  input  logic             pi_res_ready,
  output logic [7:0]       po_cnt0,
  output logic [7:0]       po_cnt1
);

  state_t           state;
  state_t           state_next;
  logic             last_id;
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;
  logic [1:0]       grant;
  logic             can_accept;
  logic             accept;
  logic             acc_id;
  logic             res_xfer;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_b;

  assign po_res_valid = (state == FULL);
  assign res_xfer     = po_res_valid & pi_res_ready;
  // A held result may drain and be replaced at the same edge.
  assign can_accept   = ~po_res_valid | pi_res_ready;
  assign grant        = rr_grant(pi_req0_valid, pi_req1_valid, last_id);

  assign po_req0_ready = can_accept & grant[0] & ~rst;
  assign po_req1_ready = can_accept & grant[1] & ~rst;
  assign accept        = po_req0_ready | po_req1_ready;
  assign acc_id        = po_req1_ready ? REQ1_ID : REQ0_ID;

  // Operand mux for the granted requester.
  always_comb begin
    acc_a = '0;
    acc_b = '0;
    if (acc_id == REQ1_ID) begin
      acc_a = pi_req1_a;
      acc_b = pi_req1_b;
    end else begin
      acc_a = pi_req0_a;
      acc_b = pi_req0_b;
    end
  end

  // Result-stage occupancy next-state.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (accept) state_next = FULL;
        else        state_next = EMPTY;
      end
      FULL: begin
        if (res_xfer && !accept) state_next = EMPTY;
        else                     state_next = FULL;
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register; pointer resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      last_id <= REQ1_ID;
    end else begin
      state <= state_next;
      if (accept) last_id <= acc_id;
      else        last_id <= last_id;
    end
  end

  // Completed-result counters, wrapping at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else if (res_xfer) begin
      if (po_res_id == REQ1_ID) begin
        cnt1 <= cnt1 + 8'd1;
      end else begin
        cnt0 <= cnt0 + 8'd1;
      end
    end else begin
      cnt0 <= cnt0;
      cnt1 <= cnt1;
    end
  end

  assign po_cnt0 = cnt0;
  assign po_cnt1 = cnt1;

  and_reg_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .a     (acc_a),
    .b     (acc_b),
    .id_in (acc_id),
    .data  (po_res_data),
    .id    (po_res_id)
  );

endmodule

// File: tb/tb_and_unit_arb.sv
// Directed bench for and_unit_arb: vector table plus hand-written tie, stall,
// async-reset and counter-wrap sequences.
module tb_and_unit_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       res_valid, res_id, res_ready;
  logic [7:0] res_data, cnt0, cnt1;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       v0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       v1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       rr;
    logic       e_rdy0;
    logic       e_rdy1;
    logic       e_val;
    logic [7:0] e_data;
    logic       e_id;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  and_unit_arb #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .pi_req0_valid (req0_valid),
    .pi_req0_a     (req0_a),
    .pi_req0_b     (req0_b),
    .po_req0_ready (req0_ready),
    .pi_req1_valid (req1_valid),
    .pi_req1_a     (req1_a),
    .pi_req1_b     (req1_b),
    .po_req1_ready (req1_ready),
    .po_res_valid  (res_valid),
    .po_res_data   (res_data),
    .po_res_id     (res_id),
    .pi_res_ready  (res_ready),
    .po_cnt0       (cnt0),
    .po_cnt1       (cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                       input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = rr;
  endtask

  initial begin
    //               v0    a0     b0     v1    a1     b1     rr    rdy0  rdy1  val   data   id    c0     c1
    vecs[0]  = '{1'b1, 8'hF0, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hAA, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0A, 1'b1, 8'd1, 8'd0};
    vecs[2]  = '{1'b1, 8'hFF, 8'h55, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'd1, 8'd1};
    vecs[3]  = '{1'b1, 8'h0F, 8'hF3, 1'b1, 8'hC3, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'd2, 8'd1};
    vecs[4]  = '{1'b1, 8'h0F, 8'hF3, 1'b1, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'd2, 8'd1};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd2, 8'd2};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd2, 8'd2};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b1, 8'd2, 8'd2};
    vecs[8]  = '{1'b1, 8'h81, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b1, 8'd2, 8'd2};
    vecs[9]  = '{1'b1, 8'h81, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 8'd2, 8'd3};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 8'd3, 8'd3};

    rst = 1'b1;
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst ready0", req0_ready, 1'b0);
    chk("rst ready1", req1_ready, 1'b0);
    chk("rst valid", res_valid, 1'b0);
    chk("rst data", res_data, 8'h00);
    chk("rst id", res_id, 1'b0);
    chk("rst cnt0", cnt0, 8'd0);
    chk("rst cnt1", cnt1, 8'd0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].rr);
      #1;
      chk($sformatf("vec%0d ready0", i), req0_ready, vecs[i].e_rdy0);
      chk($sformatf("vec%0d ready1", i), req1_ready, vecs[i].e_rdy1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d valid", i), res_valid, vecs[i].e_val);
      chk($sformatf("vec%0d data", i), res_data, vecs[i].e_data);
      chk($sformatf("vec%0d id", i), res_id, vecs[i].e_id);
      chk($sformatf("vec%0d cnt0", i), cnt0, vecs[i].e_c0);
      chk($sformatf("vec%0d cnt1", i), cnt1, vecs[i].e_c1);
    end

    // Reset while a result is stalled in the stage.
    @(negedge clk);
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("stall fill valid", res_valid, 1'b1);
    chk("stall fill data", res_data, 8'hFF);
    @(negedge clk);
    #1;
    chk("stall ready0", req0_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async rst valid", res_valid, 1'b0);
    chk("async rst data", res_data, 8'h00);
    chk("async rst id", res_id, 1'b0);
    chk("async rst cnt0", cnt0, 8'd0);
    chk("async rst cnt1", cnt1, 8'd0);
    chk("async rst ready0", req0_ready, 1'b0);

    // Tie after reset: grants alternate starting with requester 0.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h11, 8'h1F, 1'b1, 8'h22, 8'h2E, 1'b1);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      chk($sformatf("tie%0d ready0", j), req0_ready, (j % 2 == 0));
      chk($sformatf("tie%0d ready1", j), req1_ready, (j % 2 == 1));
      @(posedge clk);
      #1;
      chk($sformatf("tie%0d valid", j), res_valid, 1'b1);
      chk($sformatf("tie%0d id", j), res_id, (j % 2 == 1));
      chk($sformatf("tie%0d data", j), res_data, (j % 2 == 1) ? 8'h22 : 8'h11);
    end

    // Backpressure for three cycles, then same-cycle drain and refill.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      chk($sformatf("bp%0d ready0", k), req0_ready, 1'b0);
      chk($sformatf("bp%0d ready1", k), req1_ready, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d data", k), res_data, 8'h22);
      chk($sformatf("bp%0d id", k), res_id, 1'b1);
      chk($sformatf("bp%0d valid", k), res_valid, 1'b1);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    chk("release ready0", req0_ready, 1'b1);
    chk("release ready1", req1_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("release id", res_id, 1'b0);
    chk("release data", res_data, 8'h11);
    chk("release cnt0", cnt0, 8'd2);
    chk("release cnt1", cnt1, 8'd2);

    // Counter wrap on requester 1.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h5A, 8'hFF, 1'b1);
    repeat (256) @(posedge clk);
    #1;
    chk("wrap pre cnt1", cnt1, 8'd255);
    chk("wrap pre data", res_data, 8'h5A);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    chk("wrap cnt1", cnt1, 8'd0);
    chk("wrap cnt0", cnt0, 8'd0);
    chk("wrap valid", res_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
